request_capture_unit: RTL
=========================

# request_capture_unit

Upstream front end for the 4-input priority encoder. It synchronizes four asynchronous request lines, latches request events into a pending register, and drives the encoder's `W` input with the masked pending vector. It consumes the encoder's `Y`/`zero` outputs and presents the winning code on a valid/ready handshake. Accepting a grant clears the served pending bit.

## Interface
Parameters:
- `SYNC_STAGES`, default 2: synchronizer depth per request line; legal values 2 or 3.

Ports:
- `clk` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: synchronous, active-high reset.
- `req_in` input 4: raw asynchronous request lines; bit 3 has the highest priority.
- `mask` input 4: per-line enable; 1 = line may be presented; synchronous to `clk`.
- `W` output 4: `pending & mask`, combinational from registers and `mask`; wired to the encoder `W`.
- `code_in` input 2: encoder `Y`.
- `zero_in` input 1: encoder `zero`.
- `irq_valid` output 1: the value on `irq_code` is being offered.
- `irq_code` output 2: registered index of the request being offered.
- `irq_ready` input 1: consumer accepts the offered code.
- `overflow` output 4: sticky per-line flag; a new event arrived while that line was already pending.
- `ovf_clear` input 1: synchronous clear of all `overflow` bits.

## Operation
- Synchronizer: `SYNC_STAGES` flops per line, then one delay flop `sync_d`. The synchronized level is `sync`.
- Event:
  - With the edge-detect macro (see Configuration): `event[i] = sync[i] & ~sync_d[i]`.
  - Without it: `event[i] = sync[i]`.
- Pending update for each bit `i`, evaluated every cycle:
  - `pending[i] <= event[i] | (pending[i] & ~clr[i])`.
  - `clr[i]` is 1 only in the handshake cycle (`irq_valid & irq_ready`) with `irq_code == i`.
  - Set wins over clear.
- Overflow: `overflow[i]` sets when `event[i] & pending[i] & ~clr[i]`, and clears on `ovf_clear`. An overflow set in the same cycle as `ovf_clear` wins.
- FSM states: IDLE, PRESENT, SETTLE.
  - IDLE: if `zero_in == 0`, register `irq_code <= code_in`, set `irq_valid <= 1`, and go to PRESENT. Otherwise stay in IDLE.
  - PRESENT: hold `irq_code` and `irq_valid` stable regardless of `mask`, `req_in` or `code_in` changes. On `irq_ready`: clear the pending bit, drop `irq_valid <= 0`, and go to SETTLE.
  - SETTLE: one cycle so that `W` and the encoder reflect the cleared bit, then go to IDLE. No capture happens in SETTLE.
- `code_in` is ignored whenever `zero_in == 1`, including X values.
- Masked pending bits are retained. They are offered once they are unmasked.
- A line masked during PRESENT is still cleared when its grant is accepted.

## Timing
- Reset values: all synchronizer flops, `sync_d`, `pending` and `overflow` are 0. `irq_valid` = 0, `irq_code` = 2'b00, state = IDLE, so `W` = 0.
- A line held high through reset produces one event after reset is released (edge mode).
- Capture latency, for `req_in[i]` first sampled high at edge k with the line unmasked and the FSM in IDLE:
  - `pending[i]` = 1 after edge k+`SYNC_STAGES`.
  - `irq_valid` = 1 after edge k+`SYNC_STAGES`+1.
- Handshake: the transfer occurs on an edge where `irq_valid & irq_ready` is high. `irq_ready` may be held high.
  - Back-to-back offers are 3 cycles apart: PRESENT, SETTLE, IDLE capture.
- Reset mid-handshake: `irq_valid` is 0 on the next cycle. All pending events and in-flight synchronizer data are lost.
- Pulses shorter than one `clk` period may be missed. This is by design.

## Configuration
- `REQ_EDGE_DETECT_EN` defined: edge-triggered capture, with overflow detection as above.
- Undefined: level-sensitive.
  - `pending[i]` re-sets every cycle while `sync[i]` is high. A granted line still held high is re-offered after SETTLE.
  - `overflow` is tied to 4'b0000 and `ovf_clear` is ignored.

## Test plan
- Reset, edge mode, `SYNC_STAGES`=2, `mask`=4'hF, pulse `req_in`=4'b0100 sampled at edge k -> `W`=4'b0100 after k+2; `irq_valid`=1 with `irq_code`=2'b10 after k+3. With `irq_ready`=1: `W`=0 and `irq_valid`=0 after k+4, and no further offers.
- `req_in`=4'b1011 in one cycle, `irq_ready` tied 1 -> codes offered in order 11, 01, 00, spaced 3 cycles apart; `W` ends at 0.
- `mask`=4'b0111, `req_in[3]` pulse -> `W`=0 and `irq_valid` stays 0. Set `mask`=4'hF -> code 11 is offered 1 cycle after `W`=4'b1000.
- Two pulses on `req_in[1]` while its bit is pending and `irq_ready`=0 -> `overflow`=4'b0010. After `ovf_clear` -> `overflow`=0; `pending[1]` is still 1.
- New edge on `req_in[2]` arriving (after sync) in the same cycle as the grant of code 10 -> `pending[2]` remains 1 and code 10 is offered again after SETTLE.
- Assert `reset` while `irq_valid`=1 -> next cycle `irq_valid`=0, `irq_code`=0, `W`=0, `overflow`=0. Level mode only: `req_in[0]` held high -> code 00 is re-offered every 3 cycles with `irq_ready`=1.

Source files
------------

// File: rtl/request_capture_unit.sv
// Request front end for the 4-input priority encoder: synchronizes requests, latches them as pending, and offers the winning code on a valid/ready handshake.
// Define REQ_EDGE_DETECT_EN for edge-triggered capture with overflow flags; level-sensitive otherwise.
`timescale 1ns/1ps

module request_capture_unit #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] req_in,
  input  logic [3:0] mask,
  output logic [3:0] W,
  input  logic [1:0] code_in,
  input  logic       zero_in,
  output logic       irq_valid,
  output logic [1:0] irq_code,
  input  logic       irq_ready,
  output logic [3:0] overflow,
  input  logic       ovf_clear
);

  localparam int unsigned N_LINES = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESENT = 2'd1,
    SETTLE  = 2'd2
  } state_t;

  state_t               state;
  logic [N_LINES-1:0]   sync_ff [SYNC_STAGES];
  logic [N_LINES-1:0]   sync;
  logic [N_LINES-1:0]   sync_d;
  logic [N_LINES-1:0]   req_event;
  logic [N_LINES-1:0]   pending;
  logic [N_LINES-1:0]   clr;
  logic                 handshake;

  // Synchronizer chain plus one delay flop for edge detection
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int s = 0; s < int'(SYNC_STAGES); s++) begin
        sync_ff[s] <= '0;
      end
      sync_d <= '0;
    end else begin
      sync_ff[0] <= req_in;
      for (int s = 1; s < int'(SYNC_STAGES); s++) begin
        sync_ff[s] <= sync_ff[s-1];
      end
      sync_d <= sync;
    end
  end

  assign sync      = sync_ff[SYNC_STAGES-1];
  assign handshake = irq_valid & irq_ready;
  assign clr       = handshake ? (N_LINES'(1) << irq_code) : '0;
  assign W         = pending & mask;

`ifdef REQ_EDGE_DETECT_EN
  assign req_event = sync & ~sync_d;

  // Sticky overflow: a new event on a line that stays pending; a set beats the clear
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow <= '0;
    end else begin
      overflow <= (ovf_clear ? '0 : overflow) | (req_event & pending & ~clr);
    end
  end
`else
  logic unused_level;

  assign req_event    = sync;
  assign overflow     = '0;
  assign unused_level = ^{sync_d, ovf_clear};
`endif

  // Set wins over the grant clear
  always_ff @(posedge clk) begin
    if (reset) begin
      pending <= '0;
    end else begin
      pending <= req_event | (pending & ~clr);
    end
  end

  // Offer FSM: capture in IDLE, hold through PRESENT, one SETTLE cycle after each grant
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      irq_valid <= 1'b0;
      irq_code  <= 2'b00;
    end else begin
      case (state)
        IDLE: begin
          if (zero_in == 1'b0) begin
            irq_code  <= code_in;
            irq_valid <= 1'b1;
            state     <= PRESENT;
          end
        end
        PRESENT: begin
          if (irq_ready) begin
            irq_valid <= 1'b0;
            state     <= SETTLE;
          end
        end
        SETTLE: begin
          state <= IDLE;
        end
        default: begin
          irq_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule
